// File: rtl/acl2_mode_sequencer.sv
// Command sequencer for the PMOD ACL2 driver: soft reset, init and start commands over the
// command-ready handshake, mode/preset re-initialisation and a measurement-stream watchdog.
module acl2_mode_sequencer #(
    parameter int FCLK                 = 20000000,
    parameter int parm_fast_simulation = 0,
    parameter int parm_pwrup_wait_ms   = 10,
    parameter int parm_watchdog_ms     = 100,
    parameter int parm_ack_timeout     = 16
) (
    input  logic       i_clk_20mhz,
    input  logic       i_rstn_20mhz,
    input  logic       i_sw_linked,
    input  logic [3:0] i_enum_active,
    input  logic [3:0] i_enum_inactive,
    input  logic       i_command_ready,
    input  logic       i_data_valid,
    output logic       o_cmd_soft_reset_acl2,
    output logic       o_cmd_init_linked_mode,
    output logic       o_cmd_start_linked_mode,
    output logic       o_cmd_init_measur_mode,
    output logic       o_cmd_start_measur_mode,
    output logic       o_running,
    output logic       o_mode_linked,
    output logic [7:0] o_wdog_count,
    output logic [3:0] o_state
);

    localparam int          TICK_DIV  = (parm_fast_simulation != 0) ? 100 : FCLK / 1000;
    localparam logic [31:0] TICK_LAST = 32'(TICK_DIV - 1);
    localparam logic [15:0] PWR_LAST  = 16'(parm_pwrup_wait_ms - 1);
    localparam logic [15:0] WDOG_LAST = 16'(parm_watchdog_ms - 1);
    localparam logic [7:0]  ACK_LAST  = 8'(parm_ack_timeout - 1);

    typedef enum logic [3:0] {
        ST_PWRUP       = 4'd0,
        ST_ISSUE_RST   = 4'd1,
        ST_WAIT_RST    = 4'd2,
        ST_RST_DLY     = 4'd3,
        ST_ISSUE_INIT  = 4'd4,
        ST_WAIT_INIT   = 4'd5,
        ST_ISSUE_START = 4'd6,
        ST_WAIT_START  = 4'd7,
        ST_RUN         = 4'd8
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] presc_q, presc_d;
    logic [15:0] dly_q, dly_d;
    logic [15:0] wd_q, wd_d;
    logic [7:0]  ack_q, ack_d;
    logic        phase_b_q, phase_b_d;
    logic        mode_q, mode_d;
    logic [3:0]  act_q, act_d;
    logic [3:0]  inact_q, inact_d;
    logic [7:0]  wdog_cnt_q, wdog_cnt_d;
    logic        running_q, running_d;
    logic        cmd_rst_q, cmd_rst_d;
    logic        cmd_init_l_q, cmd_init_l_d;
    logic        cmd_start_l_q, cmd_start_l_d;
    logic        cmd_init_m_q, cmd_init_m_d;
    logic        cmd_start_m_q, cmd_start_m_d;
    logic        tick_s;
    logic        in_wait_s;
    logic        wait_timeout_s;
    logic        wait_done_s;

    assign tick_s    = (presc_q == TICK_LAST);
    assign in_wait_s = (state_q == ST_WAIT_RST) || (state_q == ST_WAIT_INIT) ||
                       (state_q == ST_WAIT_START);

    // Free-running ms prescaler, wraps at its terminal count.
    always_comb begin
        presc_d = presc_q + 32'd1;
        if (tick_s) begin
            presc_d = 32'd0;
        end else begin
            presc_d = presc_q + 32'd1;
        end
    end

    // Next-state, handshake timers, watchdog and command pulse decode.
    always_comb begin
        state_d        = state_q;
        dly_d          = 16'd0;
        wd_d           = 16'd0;
        ack_d          = 8'd0;
        phase_b_d      = 1'b0;
        mode_d         = mode_q;
        act_d          = act_q;
        inact_d        = inact_q;
        wdog_cnt_d     = wdog_cnt_q;
        cmd_rst_d      = 1'b0;
        cmd_init_l_d   = 1'b0;
        cmd_start_l_d  = 1'b0;
        cmd_init_m_d   = 1'b0;
        cmd_start_m_d  = 1'b0;
        wait_timeout_s = 1'b0;
        wait_done_s    = 1'b0;

        // Phase A waits for ready to drop (ack), phase B for ready to return (done).
        if (in_wait_s) begin
            ack_d     = ack_q;
            phase_b_d = phase_b_q;
            if (!phase_b_q) begin
                if (!i_command_ready) begin
                    phase_b_d = 1'b1;
                end else if (ack_q == ACK_LAST) begin
                    wait_timeout_s = 1'b1;
                end else begin
                    ack_d = ack_q + 8'd1;
                end
            end else if (i_command_ready) begin
                wait_done_s = 1'b1;
            end else begin
                wait_done_s = 1'b0;
            end
        end else begin
            ack_d = 8'd0;
        end

        case (state_q)
            ST_PWRUP, ST_RST_DLY: begin
                if (tick_s) begin
                    if (dly_q == PWR_LAST) begin
                        state_d = (state_q == ST_PWRUP) ? ST_ISSUE_RST : ST_ISSUE_INIT;
                    end else begin
                        dly_d = dly_q + 16'd1;
                    end
                end else begin
                    dly_d = dly_q;
                end
            end
            ST_ISSUE_RST: begin
                if (i_command_ready) begin
                    cmd_rst_d = 1'b1;
                    state_d   = ST_WAIT_RST;
                end else begin
                    state_d = ST_ISSUE_RST;
                end
            end
            ST_WAIT_RST: begin
                if (wait_timeout_s) begin
                    state_d = ST_ISSUE_RST;
                end else if (wait_done_s) begin
                    state_d = ST_RST_DLY;
                end else begin
                    state_d = ST_WAIT_RST;
                end
            end
            ST_ISSUE_INIT: begin
                if (i_command_ready) begin
                    mode_d       = i_sw_linked;
                    act_d        = i_enum_active;
                    inact_d      = i_enum_inactive;
                    cmd_init_l_d = i_sw_linked;
                    cmd_init_m_d = !i_sw_linked;
                    state_d      = ST_WAIT_INIT;
                end else begin
                    state_d = ST_ISSUE_INIT;
                end
            end
            ST_WAIT_INIT: begin
                if (wait_timeout_s) begin
                    state_d = ST_ISSUE_INIT;
                end else if (wait_done_s) begin
                    state_d = ST_ISSUE_START;
                end else begin
                    state_d = ST_WAIT_INIT;
                end
            end
            ST_ISSUE_START: begin
                if (i_command_ready) begin
                    cmd_start_l_d = mode_q;
                    cmd_start_m_d = !mode_q;
                    state_d       = ST_WAIT_START;
                end else begin
                    state_d = ST_ISSUE_START;
                end
            end
            ST_WAIT_START: begin
                if (wait_timeout_s) begin
                    state_d = ST_ISSUE_START;
                end else if (wait_done_s) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_WAIT_START;
                end
            end
            ST_RUN: begin
                if (i_sw_linked != mode_q) begin
                    state_d = ST_ISSUE_RST;
                end else if (mode_q && ((i_enum_active != act_q) ||
                                        (i_enum_inactive != inact_q))) begin
                    state_d = ST_ISSUE_INIT;
                end else if (!mode_q) begin
                    // Data arriving on the expiry tick takes priority over recovery.
                    if (i_data_valid) begin
                        wd_d = 16'd0;
                    end else if (tick_s) begin
                        if (wd_q == WDOG_LAST) begin
                            wdog_cnt_d = (wdog_cnt_q != 8'hFF) ? wdog_cnt_q + 8'd1 : wdog_cnt_q;
                            state_d    = ST_ISSUE_RST;
                        end else begin
                            wd_d = wd_q + 16'd1;
                        end
                    end else begin
                        wd_d = wd_q;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_PWRUP;
            end
        endcase

        running_d = (state_d == ST_RUN);
    end

    // State and datapath registers, all cleared by the asynchronous reset.
    always_ff @(posedge i_clk_20mhz or negedge i_rstn_20mhz) begin
        if (!i_rstn_20mhz) begin
            state_q       <= ST_PWRUP;
            presc_q       <= 32'd0;
            dly_q         <= 16'd0;
            wd_q          <= 16'd0;
            ack_q         <= 8'd0;
            phase_b_q     <= 1'b0;
            mode_q        <= 1'b0;
            act_q         <= 4'd0;
            inact_q       <= 4'd0;
            wdog_cnt_q    <= 8'd0;
            running_q     <= 1'b0;
            cmd_rst_q     <= 1'b0;
            cmd_init_l_q  <= 1'b0;
            cmd_start_l_q <= 1'b0;
            cmd_init_m_q  <= 1'b0;
            cmd_start_m_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            presc_q       <= presc_d;
            dly_q         <= dly_d;
            wd_q          <= wd_d;
            ack_q         <= ack_d;
            phase_b_q     <= phase_b_d;
            mode_q        <= mode_d;
            act_q         <= act_d;
            inact_q       <= inact_d;
            wdog_cnt_q    <= wdog_cnt_d;
            running_q     <= running_d;
            cmd_rst_q     <= cmd_rst_d;
            cmd_init_l_q  <= cmd_init_l_d;
            cmd_start_l_q <= cmd_start_l_d;
            cmd_init_m_q  <= cmd_init_m_d;
            cmd_start_m_q <= cmd_start_m_d;
        end
    end

    assign o_cmd_soft_reset_acl2   = cmd_rst_q;
    assign o_cmd_init_linked_mode  = cmd_init_l_q;
    assign o_cmd_start_linked_mode = cmd_start_l_q;
    assign o_cmd_init_measur_mode  = cmd_init_m_q;
    assign o_cmd_start_measur_mode = cmd_start_m_q;
    assign o_running               = running_q;
    assign o_mode_linked           = mode_q;
    assign o_wdog_count            = wdog_cnt_q;
    assign o_state                 = state_q;

endmodule
